// File: rtl/hour_24_set_counter.sv
// Hour stage (00-23, BCD) of a 24-hour clock: counts minute-tens carries in run mode,
// and in set mode steps up/down from debounced-by-synchronizer buttons with hold-to-repeat.
module hour_24_set_counter #(
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       carry_in,
  input  logic       set_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic       carry_day
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_dir_up, w_dir_nxt;
  logic          w_step_up, w_step_dn;

  logic r_up_s1, r_up_s2, r_up_lvl, r_up_rise, r_up_armed;
  logic r_dn_s1, r_dn_s2, r_dn_lvl, r_dn_rise, r_dn_armed;
  logic [1:0] r_sync_valid;

  logic [3:0] r_tens, r_ones;
  logic       r_carry_day;
  logic [3:0] w_inc_tens, w_inc_ones, w_dec_tens, w_dec_ones;
  logic       w_at_max, w_act_lvl, w_oth_lvl;

  // A button held through reset must be seen low once (after the synchronizer refills) before it can arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_s1      <= 1'b0;
      r_up_s2      <= 1'b0;
      r_up_lvl     <= 1'b0;
      r_up_rise    <= 1'b0;
      r_up_armed   <= 1'b0;
      r_dn_s1      <= 1'b0;
      r_dn_s2      <= 1'b0;
      r_dn_lvl     <= 1'b0;
      r_dn_rise    <= 1'b0;
      r_dn_armed   <= 1'b0;
      r_sync_valid <= 2'b00;
    end else begin
      r_up_s1      <= btn_up;
      r_up_s2      <= r_up_s1;
      r_up_lvl     <= r_up_s2;
      r_up_rise    <= r_up_s2 & ~r_up_lvl & r_up_armed;
      r_dn_s1      <= btn_down;
      r_dn_s2      <= r_dn_s1;
      r_dn_lvl     <= r_dn_s2;
      r_dn_rise    <= r_dn_s2 & ~r_dn_lvl & r_dn_armed;
      r_sync_valid <= {r_sync_valid[0], 1'b1};
      if (r_sync_valid[1] && !r_up_s2) r_up_armed <= 1'b1;
      if (r_sync_valid[1] && !r_dn_s2) r_dn_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_dir_up <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir_up <= w_dir_nxt;
    end
  end

  assign w_act_lvl = r_dir_up ? r_up_lvl : r_dn_lvl;
  assign w_oth_lvl = r_dir_up ? r_dn_lvl : r_up_lvl;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir_up;
    w_step_up   = 1'b0;
    w_step_dn   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (set_mode && r_up_rise && !r_dn_lvl) begin
          w_state_nxt = ST_HOLD;
          w_dir_nxt   = 1'b1;
          w_step_up   = 1'b1;
        end else if (set_mode && r_dn_rise && !r_up_lvl) begin
          w_state_nxt = ST_HOLD;
          w_dir_nxt   = 1'b0;
          w_step_dn   = 1'b1;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!set_mode || !w_act_lvl || w_oth_lvl) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == ((r_state == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
          w_state_nxt = ST_REPEAT;
          w_cnt_nxt   = '0;
          w_step_up   = r_dir_up;
          w_step_dn   = ~r_dir_up;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_at_max = (r_tens == 4'd2) && (r_ones == 4'd3);

  always_comb begin
    w_inc_tens = r_tens;
    w_inc_ones = r_ones + 4'd1;
    w_dec_tens = r_tens;
    w_dec_ones = r_ones - 4'd1;
    if (w_at_max) begin
      w_inc_tens = 4'd0;
      w_inc_ones = 4'd0;
    end else if (r_ones == 4'd9) begin
      w_inc_tens = r_tens + 4'd1;
      w_inc_ones = 4'd0;
    end
    if (r_tens == 4'd0 && r_ones == 4'd0) begin
      w_dec_tens = 4'd2;
      w_dec_ones = 4'd3;
    end else if (r_ones == 4'd0) begin
      w_dec_tens = r_tens - 4'd1;
      w_dec_ones = 4'd9;
    end
  end

  // Run mode counts carries only; set mode takes FSM steps only, so a carry there is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_carry_day <= 1'b0;
    end else begin
      r_carry_day <= 1'b0;
      if (!set_mode) begin
        if (carry_in) begin
          r_tens      <= w_inc_tens;
          r_ones      <= w_inc_ones;
          r_carry_day <= w_at_max;
        end
      end else if (w_step_up) begin
        r_tens <= w_inc_tens;
        r_ones <= w_inc_ones;
      end else if (w_step_dn) begin
        r_tens <= w_dec_tens;
        r_ones <= w_dec_ones;
      end
    end
  end

  assign hour_tens = r_tens;
  assign hour_ones = r_ones;
  assign carry_day = r_carry_day;

endmodule

// File: tb/tb_hour_24_set_counter.sv
// Bench for hour_24_set_counter: hour kept as a plain integer 0-23, button presses modelled
// as "one step at press, one after HOLD, then one per REPEAT while held", 3 edges after the raw rise.
module tb_hour_24_set_counter;

  localparam int H = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       carry_in = 1'b0;
  logic       set_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [3:0] hour_tens, hour_ones;
  logic       carry_day;

  int nCompared = 0;
  int nMismatched = 0;
  int mHour = 0;
  logic [7:0] obsHour[$];
  logic       obsCarry[$];

  hour_24_set_counter #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst_n(rst_n), .carry_in(carry_in), .set_mode(set_mode),
    .btn_up(btn_up), .btn_down(btn_down),
    .hour_tens(hour_tens), .hour_ones(hour_ones), .carry_day(carry_day)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int h);
    logic [7:0] b;
    b[7:4] = 4'(h / 10);
    b[3:0] = 4'(h % 10);
    return b;
  endfunction

  function automatic int wrap24(input int h);
    return ((h % 24) + 24) % 24;
  endfunction

  // Steps taken by the end of observation j for a press held d raw cycles.
  function automatic int stepsBy(input int j, input int d);
    int k;
    int n;
    k = j - 3;
    if (k < 0) return 0;
    if (k > d - 1) k = d - 1;
    n = 1;
    if (k >= H) n = n + 1 + (k - H) / R;
    return n;
  endfunction

  function automatic logic [7:0] expPress(input int start, input bit up, input int j, input int d);
    int n;
    n = stepsBy(j, d);
    return bcd(wrap24(up ? start + n : start - n));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit up, input int d, input int tail, input bit noisyCarry);
    obsHour.delete();
    obsCarry.delete();
    for (int j = 0; j < d + tail; j++) begin
      if (up) btn_up = (j < d);
      else    btn_down = (j < d);
      carry_in = noisyCarry ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
      obsHour.push_back({hour_tens, hour_ones});
      obsCarry.push_back(carry_day);
    end
    carry_in = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    nCompared++;
    if ({hour_tens, hour_ones, carry_day} !== 9'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_async: got %h%h cd=%b, expected 00 cd=0", hour_tens, hour_ones, carry_day);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    nCompared++;
    if ({hour_tens, hour_ones, carry_day} !== 9'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_release: got %h%h cd=%b, expected 00 cd=0", hour_tens, hour_ones, carry_day);
    end
    mHour = 0;
  endtask

  task automatic test_run_wrap();
    set_mode = 1'b0;
    for (int i = 0; i < 24; i++) begin
      carry_in = 1'b1;
      tick();
      carry_in = 1'b0;
      mHour = wrap24(mHour + 1);
      nCompared++;
      if ({hour_tens, hour_ones} !== bcd(mHour) || carry_day !== (mHour == 0)) begin
        nMismatched++;
        $display("[TB] FAIL run_wrap pulse %0d: got %h%h cd=%b, expected %h cd=%b",
                 i, hour_tens, hour_ones, carry_day, bcd(mHour), (mHour == 0));
      end
      tick();
      nCompared++;
      if ({hour_tens, hour_ones} !== bcd(mHour) || carry_day !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL run_wrap idle %0d: got %h%h cd=%b, expected %h cd=0",
                 i, hour_tens, hour_ones, carry_day, bcd(mHour));
      end
    end
  endtask

  task automatic test_run_random();
    bit expCd;
    set_mode = 1'b0;
    for (int i = 0; i < 150; i++) begin
      carry_in = ($urandom_range(0, 3) == 0);
      btn_up   = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      expCd = carry_in && (mHour == 23);
      if (carry_in) mHour = wrap24(mHour + 1);
      tick();
      nCompared++;
      if ({hour_tens, hour_ones} !== bcd(mHour) || carry_day !== expCd) begin
        nMismatched++;
        $display("[TB] FAIL run_random cycle %0d: got %h%h cd=%b, expected %h cd=%b",
                 i, hour_tens, hour_ones, carry_day, bcd(mHour), expCd);
      end
    end
    carry_in = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_set_down_wrap();
    int start;
    set_mode = 1'b0;
    while (mHour != 0) begin
      carry_in = 1'b1;
      tick();
      mHour = wrap24(mHour + 1);
    end
    carry_in = 1'b0;
    set_mode = 1'b1;
    repeat (2) tick();
    start = mHour;
    applyStimulus(1'b0, 5, 6, 1'b1);
    for (int j = 0; j < obsHour.size(); j++) begin
      nCompared++;
      if (obsHour[j] !== expPress(start, 1'b0, j, 5) || obsCarry[j] !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL down_wrap obs %0d: got %h cd=%b, expected %h cd=0",
                 j, obsHour[j], obsCarry[j], expPress(start, 1'b0, j, 5));
      end
    end
    mHour = wrap24(start - stepsBy(100, 5));
  endtask

  task automatic test_hold_repeat();
    int start;
    set_mode = 1'b1;
    while (mHour != 9) begin
      start = mHour;
      applyStimulus(1'b1, 2, 4, 1'b1);
      mHour = wrap24(start + 1);
      nCompared++;
      if (obsHour[obsHour.size() - 1] !== bcd(mHour) || obsCarry[obsCarry.size() - 1] !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL single_up from %0d: got %h, expected %h",
                 start, obsHour[obsHour.size() - 1], bcd(mHour));
      end
    end
    start = mHour;
    applyStimulus(1'b1, 30, 6, 1'b1);
    for (int j = 0; j < obsHour.size(); j++) begin
      nCompared++;
      if (obsHour[j] !== expPress(start, 1'b1, j, 30) || obsCarry[j] !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL hold_repeat obs %0d: got %h cd=%b, expected %h cd=0",
                 j, obsHour[j], obsCarry[j], expPress(start, 1'b1, j, 30));
      end
    end
    mHour = wrap24(start + stepsBy(100, 30));
  endtask

  task automatic test_both_buttons();
    int start;
    set_mode = 1'b1;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (j == 10) btn_down = 1'b0;
      tick();
      nCompared++;
      if ({hour_tens, hour_ones} !== bcd(mHour)) begin
        nMismatched++;
        $display("[TB] FAIL both_buttons cycle %0d: got %h%h, expected %h", j, hour_tens, hour_ones, bcd(mHour));
      end
    end
    btn_up = 1'b0;
    repeat (4) tick();
    start = mHour;
    applyStimulus(1'b1, 3, 4, 1'b0);
    mHour = wrap24(start + 1);
    nCompared++;
    if (obsHour[obsHour.size() - 1] !== bcd(mHour)) begin
      nMismatched++;
      $display("[TB] FAIL both_repress: got %h, expected %h", obsHour[obsHour.size() - 1], bcd(mHour));
    end
  endtask

  task automatic test_mode_exit();
    logic [7:0] exp;
    set_mode = 1'b1;
    btn_down = 1'b1;
    for (int j = 0; j < 36; j++) begin
      if (j == 6)  set_mode = 1'b0;
      if (j == 26) set_mode = 1'b1;
      tick();
      exp = bcd((j >= 3) ? wrap24(mHour - 1) : mHour);
      nCompared++;
      if ({hour_tens, hour_ones} !== exp || carry_day !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL mode_exit cycle %0d: got %h%h cd=%b, expected %h cd=0",
                 j, hour_tens, hour_ones, carry_day, exp);
      end
    end
    mHour = wrap24(mHour - 1);
    btn_down = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_set_carry();
    set_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      carry_in = 1'b1;
      tick();
      carry_in = 1'b0;
      nCompared++;
      if ({hour_tens, hour_ones} !== bcd(mHour) || carry_day !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL set_carry_ignored %0d: got %h%h cd=%b, expected %h cd=0",
                 i, hour_tens, hour_ones, carry_day, bcd(mHour));
      end
      tick();
    end
    set_mode = 1'b0;
    carry_in = 1'b1;
    tick();
    carry_in = 1'b0;
    mHour = wrap24(mHour + 1);
    nCompared++;
    if ({hour_tens, hour_ones} !== bcd(mHour)) begin
      nMismatched++;
      $display("[TB] FAIL mode_switch_carry: got %h%h, expected %h", hour_tens, hour_ones, bcd(mHour));
    end
    set_mode = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_random_presses();
    int start;
    int d;
    int tail;
    bit up;
    set_mode = 1'b1;
    for (int p = 0; p < 20; p++) begin
      start = mHour;
      up    = 1'($urandom_range(0, 1));
      d     = $urandom_range(1, 26);
      tail  = $urandom_range(4, 7);
      applyStimulus(up, d, tail, 1'b1);
      for (int j = 0; j < obsHour.size(); j++) begin
        nCompared++;
        if (obsHour[j] !== expPress(start, up, j, d) || obsCarry[j] !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL random_press %0d obs %0d (up=%0b d=%0d): got %h cd=%b, expected %h cd=0",
                   p, j, up, d, obsHour[j], obsCarry[j], expPress(start, up, j, d));
        end
      end
      mHour = wrap24(up ? start + stepsBy(1000, d) : start - stepsBy(1000, d));
    end
  endtask

  task automatic test_reset_mid_repeat();
    set_mode = 1'b1;
    btn_up   = 1'b1;
    repeat (14) tick();
    mHour = wrap24(mHour + 2);
    nCompared++;
    if ({hour_tens, hour_ones} !== bcd(mHour)) begin
      nMismatched++;
      $display("[TB] FAIL pre_reset_repeat: got %h%h, expected %h", hour_tens, hour_ones, bcd(mHour));
    end
    #2 rst_n = 1'b0;
    #1;
    nCompared++;
    if ({hour_tens, hour_ones, carry_day} !== 9'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_repeat: got %h%h cd=%b, expected 00 cd=0", hour_tens, hour_ones, carry_day);
    end
    tick();
    tick();
    rst_n = 1'b1;
    mHour = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      nCompared++;
      if ({hour_tens, hour_ones} !== 8'h00) begin
        nMismatched++;
        $display("[TB] FAIL held_after_reset cycle %0d: got %h%h, expected 00", j, hour_tens, hour_ones);
      end
    end
    btn_up = 1'b0;
    repeat (4) tick();
    applyStimulus(1'b1, 2, 4, 1'b0);
    mHour = 1;
    nCompared++;
    if (obsHour[obsHour.size() - 1] !== 8'h01) begin
      nMismatched++;
      $display("[TB] FAIL repress_after_reset: got %h, expected 01", obsHour[obsHour.size() - 1]);
    end
  endtask

  initial begin
    test_reset();
    test_run_wrap();
    test_run_random();
    test_set_down_wrap();
    test_hold_repeat();
    test_both_buttons();
    test_mode_exit();
    test_set_carry();
    test_random_presses();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
